fpa_normalize: RTL

Normalize-and-pack stage of the pipelined single-precision floating-point adder. Sits directly downstream of the mantissa add/subtract stage. Takes the unsigned mantissa sum, the pre-normalization exponent and the result sign. Produces a packed IEEE-754 binary32 word through a 2-stage, valid/ready-handshaked pipeline that counts leading zeros, shifts, adjusts the exponent and detects overflow and underflow.

---
 rtl/fpa_pkg.sv | 20 ++
 rtl/fpa_normalize_lzc24.sv | 17 +
 rtl/fpa_normalize.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fpa_pkg.sv
// rtl/fpa_pkg.sv - shared binary32 adder constants and packing helper
package fpa_pkg;

    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Field positions inside the unsigned mantissa sum from the add stage
    localparam int CARRY_BIT  = 24;
    localparam int HIDDEN_BIT = 23;

    function automatic logic [EXP_W+FRAC_W:0] fpa_pack(
        input logic              sign,
        input logic [EXP_W-1:0]  exp,
        input logic [FRAC_W-1:0] frac
    );
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fpa_normalize_lzc24.sv
// rtl/fpa_normalize_lzc24.sv - 24-bit leading-zero counter, 24 for all-zero input
module lzc24 (
    input  logic [23:0] din,
    output logic [4:0]  count
);

    // Scan upward so the highest set bit has the final say
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (din[i]) begin
                count = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fpa_normalize.sv
// rtl/fpa_normalize.sv - two-stage normalize-and-pack stage of the fp adder
module fpa_normalize
    import fpa_pkg::*;
#(
    parameter int EXP_W  = fpa_pkg::EXP_W,
    parameter int FRAC_W = fpa_pkg::FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [31:0]             in_man,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_ovf,
    output logic                    out_unf,
    output logic                    out_zero
);

    logic        s1_v_q, s1_v_d;
    logic        s1_sign_q, s1_sign_d;
    logic [7:0]  s1_exp_q, s1_exp_d;
    logic        s1_carry_q, s1_carry_d;
    logic [23:0] s1_man_q, s1_man_d;
    logic [4:0]  s1_lz_q, s1_lz_d;

    logic        s2_v_q, s2_v_d;
    logic [31:0] res_q, res_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        zero_q, zero_d;

    logic        s2_adv, s1_adv, in_fire;
    logic [4:0]  lz_in;
    logic [8:0]  exp_inc, exp_sub;
    logic [22:0] frac_sh;

    // Upper sum bits are structurally zero from the add stage
    logic unused_man_hi;
    assign unused_man_hi = ^in_man[31:25];

    lzc24 u_lzc (
        .din   (in_man[HIDDEN_BIT:0]),
        .count (lz_in)
    );

    // Handshake: in_ready looks through both stages so a full pipe never bubbles
    always_comb begin
        s2_adv   = !s2_v_q || out_ready;
        s1_adv   = s1_v_q && s2_adv;
        in_ready = !s1_v_q || s1_adv;
        in_fire  = in_valid && in_ready;
    end

    // S1 next state: capture the sum plus its carry flag and leading-zero count
    always_comb begin
        s1_v_d     = s1_v_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_carry_d = s1_carry_q;
        s1_man_d   = s1_man_q;
        s1_lz_d    = s1_lz_q;
        if (in_fire) begin
            s1_v_d     = 1'b1;
            s1_sign_d  = in_sign;
            s1_exp_d   = in_exp;
            s1_carry_d = in_man[CARRY_BIT];
            s1_man_d   = in_man[HIDDEN_BIT:0];
            s1_lz_d    = lz_in;
        end else if (s1_adv) begin
            s1_v_d     = 1'b0;
        end
    end

    // S2 next state: shift, adjust exponent at 9 bits, classify and pack
    always_comb begin
        exp_inc = {1'b0, s1_exp_q} + 9'd1;
        exp_sub = {1'b0, s1_exp_q} - {4'b0, s1_lz_q};
        frac_sh = s1_man_q[22:0] << s1_lz_q;

        s2_v_d = s2_adv ? s1_v_q : s2_v_q;
        res_d  = res_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        zero_d = zero_q;

        if (s1_adv) begin
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
            zero_d = 1'b0;
            if (s1_exp_q == EXP_MAX) begin
                res_d = fpa_pack(s1_sign_q, EXP_MAX, '0);
                ovf_d = 1'b1;
            end else if (!s1_carry_q && s1_lz_q == 5'd24) begin
                res_d  = '0;
                zero_d = 1'b1;
            end else if (s1_carry_q) begin
                if (exp_inc >= {1'b0, EXP_MAX}) begin
                    res_d = fpa_pack(s1_sign_q, EXP_MAX, '0);
                    ovf_d = 1'b1;
                end else begin
                    res_d = fpa_pack(s1_sign_q, exp_inc[7:0], s1_man_q[23:1]);
                end
            end else if (exp_sub[8] || exp_sub[7:0] == 8'd0) begin
                // Borrow or zero exponent: denormal range, flushed to signed zero
                res_d = {s1_sign_q, 31'h0};
                unf_d = 1'b1;
            end else begin
                res_d = fpa_pack(s1_sign_q, exp_sub[7:0], frac_sh);
            end
        end
    end

    // Pipeline registers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_carry_q <= 1'b0;
            s1_man_q   <= '0;
            s1_lz_q    <= '0;
            s2_v_q     <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_carry_q <= s1_carry_d;
            s1_man_q   <= s1_man_d;
            s1_lz_q    <= s1_lz_d;
            s2_v_q     <= s2_v_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid  = s2_v_q;
    assign out_result = res_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;
    assign out_zero   = zero_q;

endmodule
